// File: rtl/osc_fll_ctrl_if.sv
// osc_fll_ctrl_if: FLL control/status bundle between stimulus and controller.
// master drives enable/count/target/init; slave returns code, decode, err, lock, sat.
interface osc_fll_ctrl_if #(
  parameter int CNT_W    = 10,
  parameter int WIN_LOG2 = 2
);
  logic                            fll_en;
  logic [CNT_W-1:0]                osc_cnt;
  logic [CNT_W+WIN_LOG2-1:0]       target;
  logic [8:0]                      code_init;
  logic [8:0]                      code;
  logic [4:0]                      delay_con_lsb;
  logic [7:0]                      delay_con_msb;
  logic signed [CNT_W+WIN_LOG2:0]  err;
  logic                            locked;
  logic                            sat;

  modport master (
    output fll_en, osc_cnt, target, code_init,
    input  code, delay_con_lsb, delay_con_msb, err, locked, sat
  );

  modport slave (
    input  fll_en, osc_cnt, target, code_init,
    output code, delay_con_lsb, delay_con_msb, err, locked, sat
  );
endinterface

// File: rtl/osc_fll_ctrl.sv
// osc_fll_ctrl: FLL loop stepping the 9-bit varactor code from windowed osc counts.
// Ports: ref_clk, rst (sync, active-high), bus (slave side of osc_fll_ctrl_if).
module osc_fll_ctrl #(
  parameter int CNT_W      = 10,
  parameter int WIN_LOG2   = 2,
  parameter int SETTLE     = 3,
  parameter int TOL        = 1,
  parameter int GAIN_SHIFT = 2,
  parameter int LOCK_N     = 4
) (
  input logic           ref_clk,
  input logic           rst,
  osc_fll_ctrl_if.slave bus
);
  localparam int AW = CNT_W + WIN_LOG2;
  localparam int EW = AW + 1;
  localparam int SW = EW + 2;
  localparam logic [8:0]        CODE_MAX = 9'd287;
  localparam logic signed [SW-1:0] SUM_MAX = SW'(287);
  localparam logic [15:0]       SET_LAST = 16'(SETTLE - 1);
  localparam logic [15:0]       WIN_LAST = 16'((1 << WIN_LOG2) - 1);
  localparam logic [7:0]        LOCK_MAX = 8'(LOCK_N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MEAS,
    S_UPD
  } state_t;

  state_t                r_state, w_state;
  logic [CNT_W-1:0]      r_prev;
  logic [15:0]           r_cnt, w_cnt;
  logic [AW-1:0]         r_acc, w_acc;
  logic [8:0]            r_code, w_code;
  logic signed [EW-1:0]  r_err, w_err;
  logic [7:0]            r_lock_cnt, w_lock_cnt;
  logic                  r_locked, w_locked;
  logic                  r_sat, w_sat;

  logic [CNT_W-1:0]      w_delta;
  logic signed [EW-1:0]  w_diff;
  logic [EW-1:0]         w_abs;
  logic signed [EW-1:0]  w_step;
  logic signed [EW-1:0]  w_step_nz;
  logic signed [SW-1:0]  w_sum;
  logic                  w_in_tol;
  logic [8:0]            w_init;
  logic [7:0]            w_msb;

  // Modular subtraction makes a counter wrap invisible.
  assign w_delta   = bus.osc_cnt - r_prev;
  assign w_diff    = $signed({1'b0, r_acc}) - $signed({1'b0, bus.target});
  assign w_abs     = w_diff[EW-1] ? EW'(-w_diff) : EW'(w_diff);
  assign w_in_tol  = w_abs <= EW'(TOL);
  assign w_step    = w_diff >>> GAIN_SHIFT;
  // Small positive errors floor to zero; force a minimum upward step.
  assign w_step_nz = (w_step == '0) ? EW'(1) : w_step;
  assign w_sum     = $signed({{(SW-9){1'b0}}, r_code}) + SW'(w_step_nz);
  assign w_init    = (bus.code_init > CODE_MAX) ? CODE_MAX : bus.code_init;

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_acc      = r_acc;
    w_code     = r_code;
    w_err      = r_err;
    w_lock_cnt = r_lock_cnt;
    w_locked   = r_locked;
    w_sat      = r_sat;
    if (r_state != S_IDLE && !bus.fll_en) begin
      w_state    = S_IDLE;
      w_cnt      = '0;
      w_acc      = '0;
      w_lock_cnt = '0;
      w_locked   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_locked = 1'b0;
          if (bus.fll_en) begin
            w_code  = w_init;
            w_cnt   = '0;
            w_state = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == SET_LAST) begin
            w_cnt   = '0;
            w_acc   = '0;
            w_state = S_MEAS;
          end else begin
            w_cnt = r_cnt + 16'd1;
          end
        end
        S_MEAS: begin
          w_acc = r_acc + AW'(w_delta);
          if (r_cnt == WIN_LAST) begin
            w_cnt   = '0;
            w_state = S_UPD;
          end else begin
            w_cnt = r_cnt + 16'd1;
          end
        end
        S_UPD: begin
          w_err   = w_diff;
          w_cnt   = '0;
          w_state = S_SETTLE;
          if (w_in_tol) begin
            w_sat = 1'b0;
            if (r_lock_cnt != LOCK_MAX) begin
              w_lock_cnt = r_lock_cnt + 8'd1;
            end
            w_locked = (w_lock_cnt == LOCK_MAX);
          end else begin
            w_lock_cnt = '0;
            w_locked   = 1'b0;
            if (w_sum[SW-1]) begin
              w_code = '0;
              w_sat  = 1'b1;
            end else if (w_sum > SUM_MAX) begin
              w_code = CODE_MAX;
              w_sat  = 1'b1;
            end else begin
              w_code = w_sum[8:0];
              w_sat  = 1'b0;
            end
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_prev     <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_code     <= '0;
      r_err      <= '0;
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_prev     <= bus.osc_cnt;
      r_cnt      <= w_cnt;
      r_acc      <= w_acc;
      r_code     <= w_code;
      r_err      <= w_err;
      r_lock_cnt <= w_lock_cnt;
      r_locked   <= w_locked;
      r_sat      <= w_sat;
    end
  end

  // Thermometer of code[8:5]; codes stop at 287 so the field never exceeds 8.
  always_comb begin
    w_msb = '0;
    for (int i = 0; i < 8; i++) begin
      w_msb[i] = (r_code[8:5] > 4'(i));
    end
  end

  assign bus.code          = r_code;
  assign bus.delay_con_lsb = r_code[4:0];
  assign bus.delay_con_msb = w_msb;
  assign bus.err           = r_err;
  assign bus.locked        = r_locked;
  assign bus.sat           = r_sat;
endmodule
